// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the FSM encoding, default reset PC and the little-endian byte-insert helper.
package if_fetch_pkg;

   typedef logic [31:0] word_t;
   typedef logic [7:0]  byte_t;

   typedef enum logic {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } state_t;

   localparam word_t      RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [2:0] BYTES_PER_INST   = 3'd4;

   // Lane k of the word holds the byte read from fetch_pc + k.
   function automatic word_t insert_byte(input word_t w, input logic [1:0] idx, input byte_t b);
      word_t r;
      r = w;
      case (idx)
         2'd0:    r[7:0]   = b;
         2'd1:    r[15:8]  = b;
         2'd2:    r[23:16] = b;
         default: r[31:24] = b;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-stage bundle: decode-side control/result and the byte-wide memory read port.
// master = fetch stage, slave = decode stage plus memory arbiter.
interface if_fetch_if;
   import if_fetch_pkg::*;

   logic  stall;
   logic  jump;
   word_t jump_addr;
   logic  mem_busy;
   word_t mem_addr;
   logic  mem_re;
   byte_t mem_din;
   word_t inst;
   word_t pc;
   logic  inst_valid;

   modport master (
      input  stall, jump, jump_addr, mem_busy, mem_din,
      output mem_addr, mem_re, inst, pc, inst_valid
   );

   modport slave (
      output stall, jump, jump_addr, mem_busy, mem_din,
      input  mem_addr, mem_re, inst, pc, inst_valid
   );

endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: issues four byte reads per instruction, assembles them little-endian and
// presents {pc, inst, valid} to decode; holds under stall, restarts on jump, no prefetch.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   if_fetch_if.master  bus
);

   state_t     state_q;
   state_t     state_d;
   word_t      fetch_pc;
   logic [2:0] issue_cnt;
   logic [2:0] recv_cnt;
   logic       pend;
   logic [1:0] pend_idx;
   word_t      inst_buf;
   word_t      inst_q;
   word_t      pc_q;
   logic       valid_q;

   logic       issue;
   logic       consume;
   logic       last_byte;
   word_t      assembled;

   always_comb begin
      issue     = 1'b0;
      consume   = 1'b0;
      last_byte = 1'b0;
      assembled = inst_buf;
      state_d   = state_q;

      issue     = (state_q == FETCH) && (issue_cnt < BYTES_PER_INST) &&
                  !bus.mem_busy && !bus.jump && !rst;
      consume   = (state_q == HOLD) && valid_q && !bus.stall;
      last_byte = pend && (recv_cnt == BYTES_PER_INST - 3'd1);
      assembled = insert_byte(inst_buf, pend_idx, bus.mem_din);

      // Redirect outranks both completion and consume; a consume racing a jump is wrong-path.
      if (bus.jump)
         state_d = FETCH;
      else if ((state_q == FETCH) && last_byte)
         state_d = HOLD;
      else if (consume)
         state_d = FETCH;
   end

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= FETCH;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc  <= RESET_PC;
         issue_cnt <= '0;
         recv_cnt  <= '0;
         pend      <= 1'b0;
         pend_idx  <= '0;
         inst_buf  <= '0;
         inst_q    <= '0;
         pc_q      <= '0;
         valid_q   <= 1'b0;
      end else if (bus.jump) begin
         // Clearing pend drops the byte that returns next cycle from the abandoned path.
         fetch_pc  <= bus.jump_addr;
         issue_cnt <= '0;
         recv_cnt  <= '0;
         pend      <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         pend     <= issue;
         pend_idx <= issue_cnt[1:0];
         if (issue)
            issue_cnt <= issue_cnt + 3'd1;
         if (pend) begin
            inst_buf <= assembled;
            recv_cnt <= recv_cnt + 3'd1;
         end
         if (last_byte) begin
            inst_q  <= assembled;
            pc_q    <= fetch_pc;
            valid_q <= 1'b1;
         end
         if (consume) begin
            fetch_pc  <= fetch_pc + 32'd4;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            valid_q   <= 1'b0;
         end
      end
   end

   assign bus.mem_re     = issue;
   assign bus.mem_addr   = rst ? '0 : fetch_pc + {29'd0, issue_cnt};
   assign bus.inst       = inst_q;
   assign bus.pc         = pc_q;
   assign bus.inst_valid = valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: byte memory with one-cycle read latency, scenario tasks with inline checks.
module tb_if_fetch;
   import if_fetch_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   if_fetch_if bus();

   if_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   byte_t      mem [0:511];
   logic [8:0] rd_addr;

   always @(posedge clk) rd_addr <= bus.mem_addr[8:0];
   assign bus.mem_din = mem[rd_addr];

   // Inputs change at the falling edge; outputs are checked 1 time unit later.
   task automatic drive(input logic r, input logic s, input logic j, input word_t ja, input logic b);
      @(negedge clk);
      rst           = r;
      bus.stall     = s;
      bus.jump      = j;
      bus.jump_addr = ja;
      bus.mem_busy  = b;
      #1;
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      tests++; if (bus.mem_re !== 1'b0) begin fails++; $display("FAIL reset_re: got %b expected 0", bus.mem_re); end
      tests++; if (bus.mem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h expected 0", bus.mem_addr); end
      tests++; if (bus.inst !== 32'h0) begin fails++; $display("FAIL reset_inst: got %h expected 0", bus.inst); end
      tests++; if (bus.pc !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h expected 0", bus.pc); end
      tests++; if (bus.inst_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", bus.inst_valid); end
   endtask

   task automatic test_basic();
      for (int k = 0; k < 6; k++) begin
         drive(1'b0, (k == 5), 1'b0, 32'h0, 1'b0);
         tests++; if (bus.mem_re !== (k < 4)) begin fails++; $display("FAIL basic_re c%0d: got %b expected %b", k, bus.mem_re, (k < 4)); end
         if (k < 4) begin
            tests++; if (bus.mem_addr !== 32'(k)) begin fails++; $display("FAIL basic_addr c%0d: got %h expected %h", k, bus.mem_addr, k); end
         end
         tests++; if (bus.inst_valid !== (k == 5)) begin fails++; $display("FAIL basic_valid c%0d: got %b expected %b", k, bus.inst_valid, (k == 5)); end
      end
      tests++; if (bus.inst !== 32'h0010_0513) begin fails++; $display("FAIL basic_inst: got %h expected 00100513", bus.inst); end
      tests++; if (bus.pc !== 32'h0) begin fails++; $display("FAIL basic_pc: got %h expected 0", bus.pc); end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
         tests++; if (bus.inst !== 32'h0010_0513 || bus.pc !== 32'h0 || bus.inst_valid !== 1'b1)
            begin fails++; $display("FAIL stall_hold %0d: got inst=%h pc=%h v=%b expected 00100513/0/1", i, bus.inst, bus.pc, bus.inst_valid); end
         tests++; if (bus.mem_re !== 1'b0) begin fails++; $display("FAIL stall_re %0d: got %b expected 0", i, bus.mem_re); end
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      tests++; if (bus.inst_valid !== 1'b1 || bus.mem_re !== 1'b0) begin fails++; $display("FAIL stall_release: got v=%b re=%b expected 1/0", bus.inst_valid, bus.mem_re); end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      tests++; if (bus.mem_addr !== 32'h4 || bus.mem_re !== 1'b1) begin fails++; $display("FAIL stall_next: got addr=%h re=%b expected 4/1", bus.mem_addr, bus.mem_re); end
      tests++; if (bus.inst_valid !== 1'b0) begin fails++; $display("FAIL stall_next_valid: got %b expected 0", bus.inst_valid); end
   endtask

   task automatic test_jump_hold();
      for (int k = 1; k < 6; k++) drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      tests++; if (bus.inst_valid !== 1'b1 || bus.pc !== 32'h4 || bus.inst !== 32'h0010_0093)
         begin fails++; $display("FAIL second_inst: got v=%b pc=%h inst=%h expected 1/4/00100093", bus.inst_valid, bus.pc, bus.inst); end
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
         if (k == 0) begin
            tests++; if (bus.mem_addr !== 32'h8) begin fails++; $display("FAIL third_addr: got %h expected 8", bus.mem_addr); end
         end
      end
      drive(1'b0, 1'b0, 1'b1, 32'h180, 1'b0);
      tests++; if (bus.inst_valid !== 1'b1 || bus.pc !== 32'h8 || bus.inst !== 32'h0020_0133)
         begin fails++; $display("FAIL hold_pc8: got v=%b pc=%h inst=%h expected 1/8/00200133", bus.inst_valid, bus.pc, bus.inst); end
      tests++; if (bus.mem_re !== 1'b0) begin fails++; $display("FAIL hold_jump_re: got %b expected 0", bus.mem_re); end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      tests++; if (bus.inst_valid !== 1'b0) begin fails++; $display("FAIL hold_jump_flush: got %b expected 0", bus.inst_valid); end
      tests++; if (bus.mem_addr !== 32'h180 || bus.mem_re !== 1'b1) begin fails++; $display("FAIL hold_jump_target: got addr=%h re=%b expected 180/1", bus.mem_addr, bus.mem_re); end
   endtask

   task automatic test_jump_fetch();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
      tests++; if (bus.mem_re !== 1'b0) begin fails++; $display("FAIL jf_noissue: got %b expected 0", bus.mem_re); end
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
         tests++; if (bus.mem_addr !== 32'h100 + 32'(k) || bus.mem_re !== 1'b1)
            begin fails++; $display("FAIL jf_addr %0d: got addr=%h re=%b expected %h/1", k, bus.mem_addr, bus.mem_re, 32'h100 + 32'(k)); end
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      tests++; if (bus.inst_valid !== 1'b0 || bus.mem_re !== 1'b0) begin fails++; $display("FAIL jf_early: got v=%b re=%b expected 0/0", bus.inst_valid, bus.mem_re); end
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      tests++; if (bus.inst_valid !== 1'b1 || bus.pc !== 32'h100 || bus.inst !== 32'h0000_006F)
         begin fails++; $display("FAIL jf_result: got v=%b pc=%h inst=%h expected 1/100/0000006f", bus.inst_valid, bus.pc, bus.inst); end
   endtask

   task automatic test_reset_mid();
      drive(1'b0, 1'b1, 1'b1, 32'h40, 1'b0);
      tests++; if (bus.mem_re !== 1'b0) begin fails++; $display("FAIL rm_jump_re: got %b expected 0", bus.mem_re); end
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
         tests++; if (bus.mem_addr !== 32'h40 + 32'(k)) begin fails++; $display("FAIL rm_addr %0d: got %h expected %h", k, bus.mem_addr, 32'h40 + 32'(k)); end
      end
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      tests++; if (bus.mem_re !== 1'b0 || bus.mem_addr !== 32'h0) begin fails++; $display("FAIL rm_during: got re=%b addr=%h expected 0/0", bus.mem_re, bus.mem_addr); end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      tests++; if (bus.inst !== 32'h0 || bus.pc !== 32'h0 || bus.inst_valid !== 1'b0)
         begin fails++; $display("FAIL rm_outputs: got inst=%h pc=%h v=%b expected 0/0/0", bus.inst, bus.pc, bus.inst_valid); end
      tests++; if (bus.mem_re !== 1'b1 || bus.mem_addr !== 32'h0) begin fails++; $display("FAIL rm_restart: got re=%b addr=%h expected 1/0", bus.mem_re, bus.mem_addr); end
      for (int k = 1; k < 6; k++) begin
         drive(1'b0, (k == 5), 1'b0, 32'h0, 1'b0);
         tests++; if (bus.inst_valid !== (k == 5)) begin fails++; $display("FAIL rm_valid c%0d: got %b expected %b", k, bus.inst_valid, (k == 5)); end
      end
      tests++; if (bus.inst !== 32'h0010_0513 || bus.pc !== 32'h0) begin fails++; $display("FAIL rm_inst: got inst=%h pc=%h expected 00100513/0", bus.inst, bus.pc); end
   endtask

   task automatic test_busy();
      logic  exp_re [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      word_t exp_ad [8] = '{32'h0, 32'h1, 32'h1, 32'h1, 32'h2, 32'h3, 32'h4, 32'h4};
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         drive(1'b0, (k == 7), 1'b0, 32'h0, (k == 1 || k == 2));
         tests++; if (bus.mem_re !== exp_re[k]) begin fails++; $display("FAIL busy_re c%0d: got %b expected %b", k, bus.mem_re, exp_re[k]); end
         if (exp_re[k]) begin
            tests++; if (bus.mem_addr !== exp_ad[k]) begin fails++; $display("FAIL busy_addr c%0d: got %h expected %h", k, bus.mem_addr, exp_ad[k]); end
         end
         tests++; if (bus.inst_valid !== (k == 7)) begin fails++; $display("FAIL busy_valid c%0d: got %b expected %b", k, bus.inst_valid, (k == 7)); end
      end
      tests++; if (bus.inst !== 32'h0010_0513) begin fails++; $display("FAIL busy_inst: got %h expected 00100513", bus.inst); end
   endtask

   task automatic test_wrap();
      drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1);
      tests++; if (bus.mem_re !== 1'b0) begin fails++; $display("FAIL wrap_jump_re: got %b expected 0", bus.mem_re); end
      for (int k = 0; k < 6; k++) begin
         drive(1'b0, (k == 5), 1'b0, 32'h0, 1'b0);
         if (k < 4) begin
            tests++; if (bus.mem_addr !== 32'hFFFF_FFFE + 32'(k))
               begin fails++; $display("FAIL wrap_addr c%0d: got %h expected %h", k, bus.mem_addr, 32'hFFFF_FFFE + 32'(k)); end
         end
      end
      tests++; if (bus.inst_valid !== 1'b1 || bus.pc !== 32'hFFFF_FFFE || bus.inst !== 32'h0513_BBAA)
         begin fails++; $display("FAIL wrap_result: got v=%b pc=%h inst=%h expected 1/fffffffe/0513bbaa", bus.inst_valid, bus.pc, bus.inst); end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      tests++; if (bus.mem_addr !== 32'h0000_0002 || bus.mem_re !== 1'b1)
         begin fails++; $display("FAIL wrap_next: got addr=%h re=%b expected 00000002/1", bus.mem_addr, bus.mem_re); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 8'(i) ^ 8'h5A;
      mem[0]     = 8'h13; mem[1]     = 8'h05; mem[2]     = 8'h10; mem[3]     = 8'h00;
      mem[4]     = 8'h93; mem[5]     = 8'h00; mem[6]     = 8'h10; mem[7]     = 8'h00;
      mem[8]     = 8'h33; mem[9]     = 8'h01; mem[10]    = 8'h20; mem[11]    = 8'h00;
      mem[9'h100] = 8'h6F; mem[9'h101] = 8'h00; mem[9'h102] = 8'h00; mem[9'h103] = 8'h00;
      mem[9'h1FE] = 8'hAA; mem[9'h1FF] = 8'hBB;
      bus.stall     = 1'b0;
      bus.jump      = 1'b0;
      bus.jump_addr = 32'h0;
      bus.mem_busy  = 1'b0;

      test_reset();
      test_basic();
      test_stall();
      test_jump_hold();
      test_jump_fetch();
      test_reset_mid();
      test_busy();
      test_wrap();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
Instruction-fetch stage directly upstream of the decode stage. It owns the PC and reads each 32-bit instruction as four byte reads over the shared byte-wide memory port. It assembles the bytes little-endian and presents {pc, inst, valid} to decode. It honours decode's stall and its jump redirect (jump/branch resolved in decode), flushing any wrong-path fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall_i  in  1  decode cannot accept; hold presented instruction
jump_i  in  1  redirect request from decode
jump_addr_i  in  32  redirect target
mem_busy_i  in  1  memory stage owns the port this cycle; fetch must not issue
mem_addr_o  out  32  byte address of fetch read
mem_re_o  out  1  fetch read enable
mem_din_i  in  8  read data; returns exactly 1 cycle after the issuing cycle
inst_o  out  32  assembled instruction
pc_o  out  32  address of inst_o
inst_valid_o  out  1  inst_o/pc_o valid for decode

Behaviour:
- Reset (rst=1 at an edge): fetch_pc<=RESET_PC, state<=FETCH, issue_cnt<=0, recv_cnt<=0, pend<=0, inst_o<=0, pc_o<=0, inst_valid_o<=0. While rst=1, mem_re_o=0 and mem_addr_o=0. Reset mid-fetch discards all bytes; the in-flight return is ignored (pend cleared).
- States: FETCH (issuing/collecting bytes) and HOLD (instruction presented).
- mem_re_o = (state==FETCH) && issue_cnt<4 && !mem_busy_i && !jump_i && !rst. This is combinational from registered state.
- mem_addr_o = fetch_pc + issue_cnt, 32-bit wrap.
- Issue: each cycle with mem_re_o=1, issue_cnt++ and pend<=1 with index issue_cnt. Otherwise pend<=0. mem_busy_i only delays issue; a byte already in flight is still collected.
- Collect: when pend=1, inst_buf[8k+7:8k]<=mem_din_i for k=pend index, and recv_cnt++.
- When the 4th byte is captured: inst_o<=assembled word, pc_o<=fetch_pc, inst_valid_o<=1, state<=HOLD.
- Latency: with no busy/stall, bytes issue in c0..c3 and return in c1..c4; inst_valid_o=1 in c5.
- HOLD: outputs are held stable while stall_i=1. Consume = inst_valid_o && !stall_i. On consume: fetch_pc<=fetch_pc+4, counters<=0, inst_valid_o<=0, state<=FETCH. New issue starts the following cycle, so there is no prefetch.
- Redirect: jump_i=1 in any state, regardless of stall_i, has top priority. It sets fetch_pc<=jump_addr_i, state<=FETCH, counters<=0, pend<=0, inst_valid_o<=0, and no issue that cycle. A byte returning the next cycle is dropped. jump_addr_i is used as given; there is no alignment check.
- Simultaneous jump_i and consume: jump wins, and the presented instruction is flushed (wrong path).
- Simultaneous mem_busy_i and jump_i: redirect applies, and no issue.
- fetch_pc+4 wraps modulo 2^32.

Decomposition:
- Add the state encodings (FETCH, HOLD) and RESET_PC default to defines.v alongside the existing opcode constants.
- No sub-module. Byte assembly and counters are too small to split. The decode-side pipeline register remains a separate existing block.

Test Plan:
1. Reset, then release; memory holds 0x13,0x05,0x10,0x00 at addresses 0..3 → mem_addr_o 0,1,2,3 in c0..c3, inst_o=0x00100513, pc_o=0, inst_valid_o=1 in c5.
2. mem_busy_i=1 during c1..c2 of the first fetch → issues at c0,c3,c4,c5, inst_valid_o rises c7, inst_o unchanged from scenario 1.
3. stall_i=1 for 3 cycles while valid → inst_o/pc_o stable, mem_re_o=0. Release → next cycle mem_addr_o=4, valid low.
4. jump_i=1, jump_addr_i=0x100 in c2 of a fetch (byte 1 in flight) → no issue in c2, c3 data ignored, mem_addr_o=0x100..0x103 from c3, pc_o=0x100 when valid.
5. jump_i=1 with stall_i=0 while HOLD at pc 0x8 → no consume, valid drops, next fetch from jump target not 0xC.
6. rst=1 for one cycle during c3 of a fetch at pc 0x40 → all outputs 0, fetch restarts at RESET_PC, no stale bytes in inst_o.
